// File: rtl/return_buffer_write_arbiter.sv
// Round-robin arbiter that hands the byte-wide return-buffer FIFO write port to one lane
// per 16-byte output word, padding the word with pull_down when a stream ends early.
module return_buffer_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WORD_BYTES = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                        system_clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wren,
  output logic [DATA_W-1:0]           fifo_wrdata,
  input  logic                        fifo_full,
  output logic                        fifo_pull_down,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [CNT_W-1:0]            words_committed
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BC_W  = $clog2(WORD_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;

  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WORD_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   IDX_NUM  = (IDX_W + 1)'(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               busy_q, busy_d;

  logic               pick_found_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [IDX_W:0]     cand_c;
  logic [IDX_W-1:0]   next_ptr_c;

  // First requesting lane at or after rr_ptr, wrapping.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = (IDX_W + 1)'(rr_ptr_q) + (IDX_W + 1)'(k);
      if (cand_c >= IDX_NUM) begin
        cand_c = cand_c - IDX_NUM;
      end
      if (!pick_found_c && req_valid[cand_c[IDX_W-1:0]]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c[IDX_W-1:0];
      end
    end
  end

  assign next_ptr_c = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    byte_cnt_d     = byte_cnt_q;
    words_d        = words_q;
    req_ready      = '0;
    fifo_wren      = 1'b0;
    fifo_wrdata    = '0;
    fifo_pull_down = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          grant_d = NUM_REQ'(1) << pick_idx_c;
          gidx_d  = pick_idx_c;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        req_ready[gidx_q] = ~fifo_full;
        fifo_wrdata       = req_data[32'(gidx_q) * DATA_W +: DATA_W];
        fifo_wren         = req_valid[gidx_q] & ~fifo_full;
        if (fifo_wren) begin
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          // A full word closes the grant even if it also carries last: no pad needed.
          if (byte_cnt_q == BC_LAST) begin
            words_d  = words_q + CNT_W'(1);
            grant_d  = '0;
            rr_ptr_d = next_ptr_c;
            state_d  = S_IDLE;
          end else if (req_last[gidx_q]) begin
            state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        fifo_pull_down = 1'b1;
        byte_cnt_d     = '0;
        words_d        = words_q + CNT_W'(1);
        grant_d        = '0;
        rr_ptr_d       = next_ptr_c;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      words_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      words_q    <= words_d;
      busy_q     <= busy_d;
    end
  end

  assign grant           = grant_q;
  assign busy            = busy_q;
  assign words_committed = words_q;

endmodule

// File: tb/tb_return_buffer_write_arbiter.sv
// Scoreboard bench for return_buffer_write_arbiter: per-lane byte queues drive the lanes,
// expected FIFO writes/pads and grant order are queued and popped by a negedge monitor.
module tb_return_buffer_write_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 32;

  logic                      system_clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wren;
  logic [DATA_W-1:0]         fifo_wrdata;
  logic                      fifo_full;
  logic                      fifo_pull_down;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [CNT_W-1:0]          words_committed;

  always #5 system_clk = ~system_clk;

  return_buffer_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WORD_BYTES(16), .CNT_W(CNT_W)
  ) dut (
    .system_clk     (system_clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_wren      (fifo_wren),
    .fifo_wrdata    (fifo_wrdata),
    .fifo_full      (fifo_full),
    .fifo_pull_down (fifo_pull_down),
    .grant          (grant),
    .busy           (busy),
    .words_committed(words_committed)
  );

  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 wr_count = 0;
  logic [8:0]         exp_q[$];          // {is_pad, data}
  logic [NUM_REQ-1:0] exp_grant_q[$];
  int                 gap_log[$];
  logic [8:0]         lane_q[NUM_REQ][$]; // {last, data}
  logic [NUM_REQ-1:0] hold = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  function automatic bit lanes_empty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (lane_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Lane driver: retire accepted bytes, then present each lane's queue head.
  initial begin : driver
    logic [NUM_REQ-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc       = '0;
    forever begin
      @(negedge system_clk);
      acc = req_valid & req_ready;
      @(posedge system_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
        if (lane_q[i].size() != 0 && !hold[i]) begin
          req_valid[i]               = 1'b1;
          req_data[i*DATA_W +: DATA_W] = lane_q[i][0][7:0];
          req_last[i]                = lane_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: FIFO events and new grants against the scoreboards; idle gaps between grants.
  initial begin : monitor
    logic [NUM_REQ-1:0] prev_g;
    int                 zero_run;
    bit                 seen;
    logic [8:0]         got_e;
    logic [8:0]         want_e;
    prev_g   = '0;
    zero_run = 0;
    seen     = 1'b0;
    forever begin
      @(negedge system_clk);
      if (rst) begin
        prev_g   = '0;
        zero_run = 0;
        seen     = 1'b0;
      end else begin
        if (fifo_wren || fifo_pull_down) begin
          if (fifo_wren) wr_count++;
          if (fifo_pull_down) check("pad_excl_wren", 64'(fifo_wren), 64'd0);
          check("evt_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            want_e = exp_q.pop_front();
            got_e  = fifo_pull_down ? 9'h100 : {1'b0, fifo_wrdata};
            check("fifo_evt", 64'(got_e), 64'(want_e));
          end
        end
        if (grant != '0 && prev_g == '0) begin
          if (seen) gap_log.push_back(zero_run);
          seen     = 1'b1;
          zero_run = 0;
          check("grant_expected", 64'(exp_grant_q.size() != 0), 64'd1);
          if (exp_grant_q.size() != 0) check("grant_order", 64'(grant), 64'(exp_grant_q.pop_front()));
        end else if (grant == '0) begin
          zero_run++;
        end
        prev_g = grant;
      end
    end
  end

  task automatic lane_load(input int lane, input logic [7:0] base, input int n);
    logic lst;
    for (int k = 0; k < n; k++) begin
      lst = (k == n - 1) || (k % 16 == 15);
      lane_q[lane].push_back({lst, 8'(base + k)});
    end
  endtask

  task automatic exp_burst(input logic [7:0] base, input int n, input bit pad);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b0, 8'(base + k)});
    if (pad) exp_q.push_back(9'h100);
  endtask

  task automatic flush_all();
    for (int i = 0; i < NUM_REQ; i++) lane_q[i].delete();
    exp_q.delete();
    exp_grant_q.delete();
  endtask

  task automatic do_reset();
    @(negedge system_clk);
    #1;
    rst       = 1'b1;
    fifo_full = 1'b0;
    hold      = '0;
    flush_all();
    repeat (2) @(negedge system_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge system_clk);
      #1;
      if (exp_q.size() == 0 && exp_grant_q.size() == 0 && !busy && lanes_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge system_clk);
      #1;
      if (wr_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int  b;
    int  g0;
    bit  ok;
    rst       = 1'b1;
    fifo_full = 1'b0;
    repeat (2) @(negedge system_clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_words", 64'(words_committed), 64'd0);
    check("rst_wren", 64'(fifo_wren), 64'd0);
    check("rst_pad", 64'(fifo_pull_down), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    #1;
    rst = 1'b0;

    // 1: lane0, one full word, no pad
    b = wr_count;
    exp_burst(8'h00, 16, 1'b0);
    exp_grant_q.push_back(NUM_REQ'(1));
    lane_load(0, 8'h00, 16);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge system_clk);
      #1;
      if (req_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t1_valid_seen", 64'(ok), 64'd1);
    @(negedge system_clk);
    #1;
    check("t1_grant_latency", 64'(grant), 64'h1);
    wait_idle(100, "t1_done");
    check("t1_writes", 64'(wr_count - b), 64'd16);
    check("t1_words", 64'(words_committed), 64'd1);
    check("t1_grant_idle", 64'(grant), 64'd0);

    // 2: lane1, 5-byte partial word then one pad cycle
    do_reset();
    b = wr_count;
    exp_burst(8'hA0, 5, 1'b1);
    exp_grant_q.push_back(NUM_REQ'(2));
    lane_load(1, 8'hA0, 5);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge system_clk);
      #1;
      if (fifo_pull_down) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_pad_seen", 64'(ok), 64'd1);
    check("t2_writes_before_pad", 64'(wr_count - b), 64'd5);
    @(negedge system_clk);
    #1;
    check("t2_pad_one_cycle", 64'(fifo_pull_down), 64'd0);
    check("t2_grant_released", 64'(grant), 64'd0);
    check("t2_words", 64'(words_committed), 64'd1);
    wait_idle(50, "t2_done");

    // 3: all lanes valid; lane0 has a second word to show the wrap back to lane0
    do_reset();
    g0 = gap_log.size();
    lane_load(0, 8'h00, 32);
    lane_load(1, 8'h40, 16);
    lane_load(2, 8'h80, 16);
    lane_load(3, 8'hC0, 16);
    exp_burst(8'h00, 16, 1'b0);
    exp_burst(8'h40, 16, 1'b0);
    exp_burst(8'h80, 16, 1'b0);
    exp_burst(8'hC0, 16, 1'b0);
    exp_burst(8'h10, 16, 1'b0);
    exp_grant_q.push_back(NUM_REQ'(1));
    exp_grant_q.push_back(NUM_REQ'(2));
    exp_grant_q.push_back(NUM_REQ'(4));
    exp_grant_q.push_back(NUM_REQ'(8));
    exp_grant_q.push_back(NUM_REQ'(1));
    wait_idle(400, "t3_done");
    check("t3_words", 64'(words_committed), 64'd5);
    check("t3_gap_count", 64'(gap_log.size() - g0), 64'd4);
    for (int i = g0; i < gap_log.size(); i++) check("t3_gap_len", 64'(gap_log[i]), 64'd1);

    // 4: fifo_full for 3 cycles at byte 7
    do_reset();
    b = wr_count;
    exp_burst(8'h30, 16, 1'b0);
    exp_grant_q.push_back(NUM_REQ'(8));
    lane_load(3, 8'h30, 16);
    wait_writes(b + 7, 100, "t4_reach_byte7");
    @(posedge system_clk);
    #1;
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge system_clk);
      #1;
      check("t4_wren_stall", 64'(fifo_wren), 64'd0);
      check("t4_ready_stall", 64'(req_ready), 64'd0);
      check("t4_count_hold", 64'(wr_count - b), 64'd7);
    end
    @(posedge system_clk);
    #1;
    fifo_full = 1'b0;
    wait_idle(100, "t4_done");
    check("t4_writes", 64'(wr_count - b), 64'd16);
    check("t4_words", 64'(words_committed), 64'd1);

    // 5: lane2 stalls mid-word while lane3 requests; no preemption
    do_reset();
    b = wr_count;
    exp_burst(8'h50, 16, 1'b0);
    exp_burst(8'h70, 16, 1'b0);
    exp_grant_q.push_back(NUM_REQ'(4));
    exp_grant_q.push_back(NUM_REQ'(8));
    lane_load(2, 8'h50, 16);
    wait_writes(b + 9, 100, "t5_reach_byte9");
    hold[2] = 1'b1;
    lane_load(3, 8'h70, 16);
    repeat (10) begin
      @(negedge system_clk);
      #1;
      check("t5_grant_held", 64'(grant), 64'h4);
    end
    hold[2] = 1'b0;
    wait_idle(200, "t5_done");
    check("t5_words", 64'(words_committed), 64'd2);

    // 6: reset at byte 4, then a fresh burst from rr_ptr 0 and byte_cnt 0
    do_reset();
    b = wr_count;
    exp_burst(8'h90, 4, 1'b0);
    exp_grant_q.push_back(NUM_REQ'(2));
    lane_load(1, 8'h90, 16);
    wait_writes(b + 4, 100, "t6_reach_byte4");
    @(posedge system_clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_grant", 64'(grant), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_pad", 64'(fifo_pull_down), 64'd0);
    check("t6_rst_wren", 64'(fifo_wren), 64'd0);
    @(negedge system_clk);
    #1;
    check("t6_bytes_before_rst", 64'(exp_q.size()), 64'd0);
    flush_all();
    @(negedge system_clk);
    #1;
    rst = 1'b0;
    check("t6_words_cleared", 64'(words_committed), 64'd0);
    exp_burst(8'hE0, 16, 1'b0);
    exp_burst(8'hF0, 3, 1'b1);
    exp_grant_q.push_back(NUM_REQ'(1));
    exp_grant_q.push_back(NUM_REQ'(2));
    lane_load(1, 8'hF0, 3);
    lane_load(0, 8'hE0, 16);
    wait_idle(200, "t6_done");
    check("t6_words", 64'(words_committed), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
